// File: rtl/tdc_hw_accum_if.sv
// rtl/tdc_hw_accum_if.sv - control, sample and result bundle for tdc_hw_accum
interface tdc_hw_accum_if #(
  parameter int N        = 64,
  parameter int MAX_LOG2 = 8
);
  localparam int HW_W  = $clog2(N) + 1;
  localparam int LW    = $clog2(MAX_LOG2 + 1);
  localparam int SUM_W = HW_W + MAX_LOG2;

  logic             start;
  logic [LW-1:0]    log2_samples;
  logic [HW_W-1:0]  hw_in;
  logic             hw_valid;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] sum_out;
  logic [HW_W-1:0]  avg_out;
  logic [HW_W-1:0]  min_out;
  logic [HW_W-1:0]  max_out;
  logic             overrun;

  modport master (
    output start, log2_samples, hw_in, hw_valid, res_ready,
    input  busy, res_valid, sum_out, avg_out, min_out, max_out, overrun
  );

  modport slave (
    input  start, log2_samples, hw_in, hw_valid, res_ready,
    output busy, res_valid, sum_out, avg_out, min_out, max_out, overrun
  );
endinterface

// File: rtl/tdc_hw_accum.sv
// rtl/tdc_hw_accum.sv - power-of-two window sum/average of TDC hamming weight
// Running min/max is built only when TDC_HW_ACCUM_MINMAX_EN is defined.
module tdc_hw_accum #(
  parameter int N        = 64,
  parameter int MAX_LOG2 = 8
) (
  input logic           clk,
  input logic           rst,
  tdc_hw_accum_if.slave bus
);
  localparam int HW_W  = $clog2(N) + 1;
  localparam int LW    = $clog2(MAX_LOG2 + 1);
  localparam int SUM_W = HW_W + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    l_q, l_d;
  logic [HW_W-1:0]  avg_q, avg_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             take;
  logic             last;
  logic [LW-1:0]    l_new;
  logic [SUM_W-1:0] acc_next;

  // A pending result blocks a new window until the consumer takes it.
  assign accept   = bus.start && (state_q != DONE || bus.res_ready);
  assign take     = (state_q == ACCUM) && !accept && bus.hw_valid;
  assign last     = (cnt_q == ((CNT_W'(1) << l_q) - CNT_W'(1)));
  assign l_new    = (bus.log2_samples > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : bus.log2_samples;
  assign acc_next = acc_q + SUM_W'(bus.hw_in);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    avg_d   = avg_q;
    ovr_d   = ovr_q;
    if (accept) begin
      state_d = ACCUM;
      l_d     = l_new;
      acc_d   = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.hw_valid) ovr_d = 1'b1;
        ACCUM: if (take) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            state_d = DONE;
            sum_d   = acc_next;
            avg_d   = HW_W'(acc_next >> l_q);
          end
        end
        DONE: begin
          if (bus.hw_valid) ovr_d = 1'b1;
          if (bus.res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      avg_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      avg_q   <= avg_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef TDC_HW_ACCUM_MINMAX_EN
  logic [HW_W-1:0] rmin_q, rmin_d, rmax_q, rmax_d;
  logic [HW_W-1:0] min_q, min_d, max_q, max_d;
  logic [HW_W-1:0] smp_min, smp_max;

  assign smp_min = (bus.hw_in < rmin_q) ? bus.hw_in : rmin_q;
  assign smp_max = (bus.hw_in > rmax_q) ? bus.hw_in : rmax_q;

  always_comb begin
    rmin_d = rmin_q;
    rmax_d = rmax_q;
    min_d  = min_q;
    max_d  = max_q;
    if (accept) begin
      rmin_d = '1;
      rmax_d = '0;
    end else if (take) begin
      rmin_d = smp_min;
      rmax_d = smp_max;
      if (last) begin
        min_d = smp_min;
        max_d = smp_max;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmin_q <= '0;
      rmax_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      rmin_q <= rmin_d;
      rmax_q <= rmax_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign bus.min_out = min_q;
  assign bus.max_out = max_q;
`else
  assign bus.min_out = '0;
  assign bus.max_out = '0;
`endif

  assign bus.busy      = (state_q == ACCUM);
  assign bus.res_valid = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.avg_out   = avg_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_tdc_hw_accum.sv
// tb/tb_tdc_hw_accum.sv - randomized and directed bench for tdc_hw_accum
module tb_tdc_hw_accum;
  localparam int N        = 64;
  localparam int MAX_LOG2 = 8;
  localparam int HW_W     = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdc_hw_accum_if #(.N(N), .MAX_LOG2(MAX_LOG2)) bus ();
  tdc_hw_accum #(.N(N), .MAX_LOG2(MAX_LOG2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  // Reference: 0 idle, 1 collecting, 2 result pending
  int m_st, m_L, m_sum, m_avg, m_min, m_max, m_ovr;
  int win[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_min();
`ifdef TDC_HW_ACCUM_MINMAX_EN
    return m_min;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_max();
`ifdef TDC_HW_ACCUM_MINMAX_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0; m_L = 0; m_sum = 0; m_avg = 0; m_min = 0; m_max = 0; m_ovr = 0;
    win.delete();
  endtask

  task automatic model_step();
    bit acc;
    int s, mn, mx;
    acc = bus.start && (m_st != 2 || bus.res_ready);
    if (acc) begin
      m_st  = 1;
      m_L   = (int'(bus.log2_samples) > MAX_LOG2) ? MAX_LOG2 : int'(bus.log2_samples);
      m_ovr = 0;
      win.delete();
    end else if (m_st == 1) begin
      if (bus.hw_valid) begin
        win.push_back(int'(bus.hw_in));
        if (win.size() == (1 << m_L)) begin
          s = 0; mn = win[0]; mx = win[0];
          foreach (win[i]) begin
            s += win[i];
            if (win[i] < mn) mn = win[i];
            if (win[i] > mx) mx = win[i];
          end
          m_sum = s;
          m_avg = (s / (1 << m_L)) % (1 << HW_W);
          m_min = mn;
          m_max = mx;
          m_st  = 2;
        end
      end
    end else begin
      if (bus.hw_valid) m_ovr = 1;
      if (m_st == 2 && bus.res_ready) m_st = 0;
    end
  endtask

  task automatic check_all();
    check("busy", 32'(bus.busy), 32'(m_st == 1));
    check("res_valid", 32'(bus.res_valid), 32'(m_st == 2));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("sum_out", 32'(bus.sum_out), 32'(m_sum));
    check("avg_out", 32'(bus.avg_out), 32'(m_avg));
    check("min_out", 32'(bus.min_out), 32'(exp_min()));
    check("max_out", 32'(bus.max_out), 32'(exp_max()));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.log2_samples = l[3:0];
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int v);
    bus.hw_valid = 1'b1;
    bus.hw_in = v[HW_W-1:0];
    cycle();
    bus.hw_valid = 1'b0;
  endtask

  initial begin
    int vals[4];
    rst = 1'b1;
    bus.start = 1'b0; bus.log2_samples = '0; bus.hw_in = '0;
    bus.hw_valid = 1'b0; bus.res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Basic window
    vals = '{10, 20, 30, 41};
    do_start(2);
    foreach (vals[i]) feed(vals[i]);
    check("basic_valid", 32'(bus.res_valid), 32'd1);
    check("basic_busy", 32'(bus.busy), 32'd0);
    check("basic_sum", 32'(bus.sum_out), 32'd101);
    check("basic_avg", 32'(bus.avg_out), 32'd25);
    bus.res_ready = 1'b1; cycle(); bus.res_ready = 1'b0;

    // Back-pressure with overrun while the result is held
    do_start(1);
    feed(5); feed(7);
    for (int i = 0; i < 5; i++) begin
      bus.hw_valid = (i == 2); bus.hw_in = 7'd3;
      cycle();
    end
    bus.hw_valid = 1'b0;
    check("bp_valid", 32'(bus.res_valid), 32'd1);
    check("bp_sum", 32'(bus.sum_out), 32'd12);
    check("bp_avg", 32'(bus.avg_out), 32'd6);
    check("bp_overrun", 32'(bus.overrun), 32'd1);
    bus.res_ready = 1'b1; cycle(); bus.res_ready = 1'b0;
    check("bp_idle", 32'(bus.res_valid | bus.busy), 32'd0);

    // Clamped full window, extra sample after completion is dropped
    do_start(15);
    for (int i = 0; i < 256; i++) feed(64);
    check("clamp_valid", 32'(bus.res_valid), 32'd1);
    check("clamp_sum", 32'(bus.sum_out), 32'd16384);
    check("clamp_avg", 32'(bus.avg_out), 32'd64);
    feed(64);
    check("clamp_hold", 32'(bus.sum_out), 32'd16384);
    bus.res_ready = 1'b1; cycle(); bus.res_ready = 1'b0;

    // Restart mid-window, simultaneous sample ignored
    do_start(2);
    feed(11); feed(12);
    bus.hw_valid = 1'b1; bus.hw_in = 7'd9;
    do_start(0);
    bus.hw_valid = 1'b0;
    check("restart_ovr", 32'(bus.overrun), 32'd0);
    feed(33);
    check("restart_sum", 32'(bus.sum_out), 32'd33);
    check("restart_avg", 32'(bus.avg_out), 32'd33);
    feed(1);
    check("done_ovr_set", 32'(bus.overrun), 32'd1);
    bus.res_ready = 1'b1;
    do_start(1);
    bus.res_ready = 1'b0;
    check("chain_busy", 32'(bus.busy), 32'd1);
    check("chain_ovr", 32'(bus.overrun), 32'd0);
    feed(20);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_valid", 32'(bus.res_valid), 32'd0);
    check("ar_sum", 32'(bus.sum_out), 32'd0);
    check("ar_overrun", 32'(bus.overrun), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    do_start(2);
    foreach (vals[i]) feed(vals[i]);
    check("post_rst_sum", 32'(bus.sum_out), 32'd101);
    bus.res_ready = 1'b1; cycle(); bus.res_ready = 1'b0;

    // Randomized traffic, including out-of-range samples
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.log2_samples = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 3));
      bus.hw_valid = ($urandom_range(0, 9) < 7);
      bus.hw_in = ($urandom_range(0, 15) == 0) ? HW_W'($urandom_range(N + 1, (1 << HW_W) - 1))
                                               : HW_W'($urandom_range(0, N));
      bus.res_ready = $urandom_range(0, 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
